// File: rtl/uart_sched.sv
// Bus master for the uart register slave: programs CLK_DIV, polls STATUS, forwards RX, round-robins TX.
// Optional RX path enabled by defining UART_SCHED_RX_EN.
module uart_sched #(
    parameter int unsigned CLK_DIV_INIT = 103
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [1:0]  req_ready,
    output logic        rx_valid,
    output logic [15:0] rx_data,
    input  logic        rx_ready,
    output logic        uart_sel,
    output logic [63:0] uart_address,
    output logic        uart_read,
    output logic [3:0]  uart_write_mask,
    output logic [63:0] uart_write_value,
    input  logic [63:0] uart_read_value
);

    typedef enum logic [1:0] {S_INIT, S_POLL, S_RX_READ, S_TX_WRITE} state_t;

    localparam logic [63:0] ADDR_CLK_DIV = 64'h0;
    localparam logic [63:0] ADDR_STATUS  = 64'h4;
    localparam logic [63:0] ADDR_DATA    = 64'h8;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        rr_pick;
    logic        rx_valid_int;

    logic        sel_c, read_c;
    logic [63:0] addr_c, wval_c;
    logic [3:0]  mask_c;
    logic [1:0]  ready_c;

    // Prefer the requester that did not win last time.
    assign rr_pick = req_valid[~last_grant_q] ? ~last_grant_q : last_grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sel_c        = 1'b1;
        read_c       = 1'b0;
        addr_c       = '0;
        mask_c       = '0;
        wval_c       = '0;
        ready_c      = '0;
        case (state_q)
            S_INIT: begin
                addr_c  = ADDR_CLK_DIV;
                mask_c  = 4'b0011;
                wval_c  = {32'b0, 32'(CLK_DIV_INIT)};
                state_d = S_POLL;
            end
            S_POLL: begin
                addr_c = ADDR_STATUS;
                read_c = 1'b1;
                // RX first: the UART holds only one received character.
                if (uart_read_value[1] && !rx_valid_int) begin
`ifdef UART_SCHED_RX_EN
                    state_d = S_RX_READ;
`else
                    state_d = S_POLL;
                    if (uart_read_value[0] && |req_valid) begin
                        grant_d = rr_pick;
                        state_d = S_TX_WRITE;
                    end
`endif
                end else if (uart_read_value[0] && |req_valid) begin
                    grant_d = rr_pick;
                    state_d = S_TX_WRITE;
                end
            end
`ifdef UART_SCHED_RX_EN
            S_RX_READ: begin
                addr_c  = ADDR_DATA;
                read_c  = 1'b1;
                state_d = S_POLL;
            end
`endif
            S_TX_WRITE: begin
                addr_c           = ADDR_DATA;
                mask_c           = 4'b0001;
                wval_c           = {48'b0, grant_q ? req_data[31:16] : req_data[15:0]};
                ready_c[grant_q] = 1'b1;
                last_grant_d     = grant_q;
                state_d          = S_POLL;
            end
            default: begin
                sel_c   = 1'b0;
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Bus outputs are masked by reset so an aborted access drops immediately.
    assign uart_sel         = reset_n & sel_c;
    assign uart_read        = reset_n & read_c;
    assign uart_address     = {64{reset_n}} & addr_c;
    assign uart_write_mask  = {4{reset_n}} & mask_c;
    assign uart_write_value = {64{reset_n}} & wval_c;
    assign req_ready        = {2{reset_n}} & ready_c;

`ifdef UART_SCHED_RX_EN
    logic        rx_valid_q, rx_valid_d;
    logic [15:0] rx_data_q, rx_data_d;

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (state_q == S_RX_READ) begin
            rx_valid_d = 1'b1;
            rx_data_d  = uart_read_value[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_valid_int = rx_valid_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
`else
    assign rx_valid_int = 1'b0;
    assign rx_valid     = 1'b0;
    assign rx_data      = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{uart_read_value, rx_ready};

endmodule

// File: tb/tb_uart_sched.sv
// Directed bench for uart_sched: expected bus cycles go through a scoreboard queue.
module tb_uart_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        uart_sel;
    logic [63:0] uart_address;
    logic        uart_read;
    logic [3:0]  uart_write_mask;
    logic [63:0] uart_write_value;
    logic [63:0] uart_read_value;

    uart_sched #(.CLK_DIV_INIT(103)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .uart_sel(uart_sel), .uart_address(uart_address), .uart_read(uart_read),
        .uart_write_mask(uart_write_mask), .uart_write_value(uart_write_value),
        .uart_read_value(uart_read_value)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [63:0] addr;
        logic        rd;
        logic [3:0]  mask;
        logic [63:0] wval;
        logic [1:0]  rdy;
        logic        rxv;
        logic [15:0] rxd;
    } acc_t;

    acc_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic last_g;
    logic [15:0] d0, d1;

    function automatic acc_t mk(input logic s, input logic [63:0] a, input logic r,
                                input logic [3:0] m, input logic [63:0] v,
                                input logic [1:0] y, input logic xv, input logic [15:0] xd);
        acc_t e;
        e = '{sel:s, addr:a, rd:r, mask:m, wval:v, rdy:y, rxv:xv, rxd:xd};
        return e;
    endfunction

    function automatic acc_t e_init();
        return mk(1'b1, 64'h0, 1'b0, 4'b0011, 64'd103, 2'b00, 1'b0, 16'h0);
    endfunction
    function automatic acc_t e_poll(input logic xv, input logic [15:0] xd);
        return mk(1'b1, 64'h4, 1'b1, 4'b0000, 64'h0, 2'b00, xv, xd);
    endfunction
    function automatic acc_t e_tx(input logic [15:0] v, input logic g, input logic xv,
                                  input logic [15:0] xd);
        return mk(1'b1, 64'h8, 1'b0, 4'b0001, {48'b0, v}, g ? 2'b10 : 2'b01, xv, xd);
    endfunction
    function automatic acc_t e_zero();
        return mk(1'b0, 64'h0, 1'b0, 4'b0000, 64'h0, 2'b00, 1'b0, 16'h0);
    endfunction

    task automatic check(input string tag);
        acc_t e, o;
        e = exp_q.pop_front();
        o = '{sel:uart_sel, addr:uart_address, rd:uart_read, mask:uart_write_mask,
              wval:uart_write_value, rdy:req_ready, rxv:rx_valid, rxd:rx_data};
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One bus cycle: drive read data, push expectation, compare at negedge, advance.
    task automatic cyc(input string tag, input logic [63:0] rv, input acc_t e);
        uart_read_value = rv;
        exp_q.push_back(e);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n         = 1'b0;
        req_valid       = 2'b00;
        req_data        = '0;
        rx_ready        = 1'b0;
        uart_read_value = '0;
        last_g          = 1'b1;

        @(negedge clk);
        exp_q.push_back(e_zero());
        check("reset_state");
        @(posedge clk);
        #1 reset_n = 1'b1;

        cyc("init_write", 64'h0, e_init());

        // Round-robin with both requesters always valid.
        d0 = 16'h000A;
        d1 = 16'h000B;
        req_valid = 2'b11;
        req_data  = {d1, d0};
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = req_valid[~last_g] ? ~last_g : last_g;
            cyc("rr_poll", 64'h1, e_poll(1'b0, 16'h0));
            cyc("rr_write", 64'h0, e_tx(g ? d1 : d0, g, 1'b0, 16'h0));
            if (g) d1 = d1 + 16'h10; else d0 = d0 + 16'h10;
            req_data = {d1, d0};
            last_g = g;
        end

        for (int k = 0; k < 10; k++)
            cyc("busy_poll", 64'h0, e_poll(1'b0, 16'h0));

        req_valid = 2'b01;
        req_data  = {16'h0, 16'h0041};
        cyc("single_poll", 64'h1, e_poll(1'b0, 16'h0));
        cyc("single_write", 64'h0, e_tx(16'h0041, 1'b0, 1'b0, 16'h0));
        last_g    = 1'b0;
        req_valid = 2'b00;
        cyc("idle_poll", 64'h1, e_poll(1'b0, 16'h0));

        req_valid = 2'b01;
        req_data  = {16'h0, 16'h0042};
`ifdef UART_SCHED_RX_EN
        cyc("rx_prio_poll", 64'h3, e_poll(1'b0, 16'h0));
        cyc("rx_read", 64'h1234_5678_9ABC_0055,
            mk(1'b1, 64'h8, 1'b1, 4'b0000, 64'h0, 2'b00, 1'b0, 16'h0));
        cyc("rx_held_poll0", 64'h2, e_poll(1'b1, 16'h0055));
        cyc("rx_held_poll1", 64'h2, e_poll(1'b1, 16'h0055));
        cyc("rx_held_txpoll", 64'h3, e_poll(1'b1, 16'h0055));
        cyc("rx_held_write", 64'h0, e_tx(16'h0042, 1'b0, 1'b1, 16'h0055));
        req_valid = 2'b00;
        rx_ready  = 1'b1;
        cyc("rx_pop_poll", 64'h0, e_poll(1'b1, 16'h0055));
        cyc("rx_empty_poll", 64'h0, e_poll(1'b0, 16'h0055));
        rx_ready  = 1'b0;
`else
        cyc("norx_poll", 64'h3, e_poll(1'b0, 16'h0));
        cyc("norx_write", 64'h0, e_tx(16'h0042, 1'b0, 1'b0, 16'h0));
        req_valid = 2'b00;
        cyc("norx_rxbit_poll", 64'h2, e_poll(1'b0, 16'h0));
        cyc("norx_idle_poll", 64'h2, e_poll(1'b0, 16'h0));
`endif
        last_g = 1'b0;

        // Reset in the middle of a TX write: access aborts, char is rewritten later.
        req_valid = 2'b10;
        req_data  = {16'h0077, 16'h0};
        cyc("abort_poll", 64'h1, e_poll(1'b0, 16'h0));
        #1 reset_n = 1'b0;
        #1;
        exp_q.push_back(e_zero());
        check("abort_outputs_zero");
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc("reinit_write", 64'h0, e_init());
        cyc("reinit_poll", 64'h1, e_poll(1'b0, 16'h0));
        cyc("rewrite", 64'h0, e_tx(16'h0077, 1'b1, 1'b0, 16'h0));
        req_valid = 2'b00;
        cyc("final_poll", 64'h1, e_poll(1'b0, 16'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_sched.md
# uart_sched

Bus-master controller sitting between two byte-stream requesters (CPU console path and debug monitor) and the memory-mapped `uart` register slave. It programs the UART clock divider after reset, polls UART status, forwards received characters to a single RX stream, and arbitrates TX characters round-robin between the two requesters. The block owns the UART's `sel/address/read/write_mask/write_value` inputs exclusively.

## Interface
- `CLK_DIV_INIT`, default 103: value written to UART CLK_DIV after reset (bit period = CLK_DIV_INIT+1 clocks).
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester TX character valid; bit i = requester i.
- `req_data` in 32: requester i data in `[16*i+15:16*i]`; only bits [7:0] meaningful on the wire.
- `req_ready` out 2: one-hot pulse; character i accepted this cycle.
- `rx_valid` out 1: received character held in `rx_data`.
- `rx_data` out 16: received character.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `uart_sel` out 1: UART access strobe.
- `uart_address` out 64: byte address; only [3:2] decoded by UART.
- `uart_read` out 1: read strobe (pops UART RX on DATA).
- `uart_write_mask` out 4: write byte enables.
- `uart_write_value` out 64: write data.
- `uart_read_value` in 64: combinational read data, valid in same cycle as `uart_sel`.

## Operation
- UART register offsets: CLK_DIV 0x0, STATUS 0x4 (bit0 tx_ready, bit1 rx_ready), DATA 0x8.
- One UART access per cycle; each FSM state is exactly one cycle with `uart_sel=1`.
- States:
  - INIT: write 0x0, mask 4'b0011, value {32'b0, CLK_DIV_INIT} -> POLL.
  - POLL: read 0x4 (`uart_read=1`, mask 0). Sample status at clock edge. If bit1 && !rx_valid -> RX_READ; else if bit0 && |req_valid -> TX_WRITE (grant registered); else stay POLL.
  - RX_READ: read 0x8, `uart_read=1`, mask 0; capture `uart_read_value[15:0]` into `rx_data`, set `rx_valid` -> POLL.
  - TX_WRITE: write 0x8, mask 4'b0001, `uart_read=0`, value {48'b0, granted req_data}; `req_ready[grant]=1` -> POLL.
- RX has priority over TX to avoid UART single-entry overrun.
- Round-robin: `last_grant` register, reset 1. Grant = other requester if valid, else the valid one. Updated on TX_WRITE.
- Requesters hold `req_valid`/`req_data` stable until `req_ready`; dropping `req_valid` after grant is illegal.
- RX handshake: `rx_valid` clears on `rx_valid && rx_ready`; if RX_READ capture coincides with a pop, new data wins and `rx_valid` stays 1. While `rx_valid` is held, UART DATA is never read.
- All `uart_*` outputs are 0 whenever not in an access state (only possible during reset).

## Timing
- Reset values: `uart_sel` 0, `uart_address` 0, `uart_read` 0, `uart_write_mask` 0, `uart_write_value` 0, `req_ready` 0, `rx_valid` 0, `rx_data` 0; FSM = INIT.
- Reset assertion is immediate (asynchronous); mid-transaction the access is aborted, no `req_ready` issued, and INIT repeats after release.
- First cycle after `reset_n` release: INIT access.
- TX latency: POLL at cycle n seeing tx_ready and req_valid -> TX_WRITE at n+1 (`req_ready` high in n+1).
- RX latency: POLL at n seeing rx_ready -> RX_READ at n+1 -> `rx_valid` high from n+2.
- The poll after TX_WRITE reads tx_ready=0 (UART busy); no double write is possible.

## Configuration
- `UART_SCHED_RX_EN`: defined -> RX path as described. Undefined -> RX_READ state and `rx_data` register removed, `rx_valid`/`rx_data` tied 0, status bit1 ignored, `rx_ready` unused; UART DATA is never read.

## Test plan
- Reset release -> cycle 1: sel=1, addr 0x0, mask 4'b0011, value 103; cycle 2: read at 0x4.
- req_valid=2'b01, req_data[15:0]=0x0041, status=0x1 -> next cycle write 0x8, mask 4'b0001, value 0x41, req_ready=2'b01 for one cycle.
- Both requesters valid, status 0x1 every poll -> grant sequence 0,1,0,1, each write separated by one POLL.
- Status 0x0 held 10 cycles with req_valid=2'b11 -> only STATUS reads, req_ready stays 0.
- Status 0x3, rx empty, DATA reads 0x...0055 -> RX_READ before TX; rx_data=0x0055, rx_valid=1; with rx_ready=0 and status 0x2 no further DATA read.
- reset_n low during TX_WRITE -> all outputs 0 same cycle, no req_ready; after release INIT then same character rewritten.
